// File: rtl/mcpu_pkg.sv
// Shared definitions for the mcpu core: opcode map, FSM states, ALU operation codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mcpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    // ALU encodings equal the low three opcode bits, so the decoder can cast directly
    typedef enum logic [2:0] {
        ALU_ADD = 3'd3,
        ALU_SUB = 3'd4,
        ALU_AND = 3'd5,
        ALU_OR  = 3'd6,
        ALU_XOR = 3'd7
    } alu_op_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_JC    = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Opcodes 3..7 are the flag-updating ALU group
    function automatic logic is_alu_op(input logic [3:0] opc);
        return (opc >= OP_ADD) && (opc <= OP_XOR);
    endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR with carry/borrow and zero flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; result valid whenever operands are.
module mcpu_alu
    import mcpu_pkg::*;
#(
    parameter int DW = 4
) (
    input  alu_op_t       op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] res_o,
    output logic          c_o,
    output logic          z_o
);

    logic [DW:0] sum;

    // Operation select; SUB carry is a borrow, logic ops clear carry
    always_comb begin
        sum   = '0;
        res_o = '0;
        c_o   = 1'b0;
        case (op_i)
            ALU_ADD: begin
                sum   = {1'b0, a_i} + {1'b0, b_i};
                res_o = sum[DW-1:0];
                c_o   = sum[DW];
            end
            ALU_SUB: begin
                res_o = a_i - b_i;
                c_o   = (a_i < b_i);
            end
            ALU_AND: res_o = a_i & b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_XOR: res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
        z_o = (res_o == '0);
    end

endmodule

// File: rtl/mcpu_core.sv
// Multi-cycle accumulator-style CPU: FETCH/EXEC(/MEM)/HALT, optional illegal-opcode trap (MCPU_ILLEGAL_TRAP_EN).
// Latency: 2 cycles per non-memory instruction, 3 + wait cycles per LOAD/STORE.
// Backpressure: stalls in MEM holding dmem_req and its qualifiers stable until dmem_ack.
module mcpu_core
    import mcpu_pkg::*;
#(
    parameter int DW   = 4,
    parameter int AW   = 4,
    parameter int NREG = 4,
    localparam int RW  = $clog2(NREG),
    localparam int IW  = 4 + RW + AW
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    input  logic          resume,
    output logic          halted,
    output logic [AW-1:0] pc_debug,
    output logic [IW-1:0] ir_debug,
    output logic [1:0]    flags_debug
`ifdef MCPU_ILLEGAL_TRAP_EN
    ,
    output logic          illegal
`endif
);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          c_q, c_d;
    logic          z_q, z_d;
    logic [DW-1:0] regs_q [NREG];

    logic          reg_we;
    logic [DW-1:0] reg_wdata;

    logic [3:0]    opc;
    logic [RW-1:0] rd;
    logic [AW-1:0] opnd;
    logic [RW-1:0] rs;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] ldi_val;
    logic [AW-1:0] pc_inc;

    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_z;

`ifdef MCPU_ILLEGAL_TRAP_EN
    logic          illegal_q, illegal_d;
`endif

    assign opc     = ir_q[IW-1:IW-4];
    assign rd      = ir_q[AW+RW-1:AW];
    assign opnd    = ir_q[AW-1:0];
    assign rs      = opnd[RW-1:0];
    // Both operands come from the pre-update register file, so rd==rs is safe
    assign rd_val  = regs_q[rd];
    assign rs_val  = regs_q[rs];
    assign ldi_val = DW'(opnd);
    assign pc_inc  = pc_q + AW'(1);

    mcpu_alu #(.DW(DW)) u_alu (
        .op_i  (alu_op_t'(opc[2:0])),
        .a_i   (rd_val),
        .b_i   (rs_val),
        .res_o (alu_res),
        .c_o   (alu_c),
        .z_o   (alu_z)
    );

    // Next-state, PC, flag and register-write decode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        c_d       = c_q;
        z_d       = z_q;
        reg_we    = 1'b0;
        reg_wdata = '0;
`ifdef MCPU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            FETCH: begin
                ir_d    = imem_data;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_inc;
                if (is_alu_op(opc)) begin
                    reg_we    = 1'b1;
                    reg_wdata = alu_res;
                    c_d       = alu_c;
                    z_d       = alu_z;
                end else begin
                    case (opc)
                        OP_NOP: ;
                        OP_LOAD, OP_STORE: begin
                            // PC advances only once the memory access completes
                            state_d = MEM;
                            pc_d    = pc_q;
                        end
                        OP_LDI: begin
                            reg_we    = 1'b1;
                            reg_wdata = ldi_val;
                        end
                        OP_JMP:  pc_d = opnd;
                        OP_JZ:   if (z_q) pc_d = opnd;
                        OP_JC:   if (c_q) pc_d = opnd;
                        OP_HALT: state_d = HALT;
                        default: begin
`ifdef MCPU_ILLEGAL_TRAP_EN
                            // Trap leaves PC on the offending instruction
                            state_d   = HALT;
                            pc_d      = pc_q;
                            illegal_d = 1'b1;
`endif
                        end
                    endcase
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    state_d = FETCH;
                    pc_d    = pc_inc;
                    if (opc == OP_LOAD) begin
                        reg_we    = 1'b1;
                        reg_wdata = dmem_rdata;
                    end
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = FETCH;
`ifdef MCPU_ILLEGAL_TRAP_EN
                    illegal_d = 1'b0;
`endif
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // Register file with a single write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[rd] <= reg_wdata;
        end
    end

`ifdef MCPU_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode indicator, cleared on resume
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) illegal_q <= 1'b0;
        else          illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`endif

    // Memory request is a pure function of state, so reset drops it immediately
    assign imem_addr   = pc_q;
    assign dmem_req    = (state_q == MEM);
    assign dmem_we     = dmem_req && (opc == OP_STORE);
    assign dmem_addr   = opnd;
    assign dmem_wdata  = rd_val;
    assign halted      = (state_q == HALT);
    assign pc_debug    = pc_q;
    assign ir_debug    = ir_q;
    assign flags_debug = {c_q, z_q};

endmodule
